imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
Controller that owns the single-port instruction memory and shares it between three requesters:
- the pipeline fetch stage (read)
- a boot/program loader (write)
- a debug read port

After reset it holds the core in reset while the loader fills memory, then hands the memory to fetch, granting debug reads in idle or starvation slots. It sits between the fetch stage, the loader/debug logic and the imem array (combinational read, word-indexed by byte address bits [IMEM_W-1:2]).

Parameters:
WIDTH, 32, instruction/data word width
IMEM_W, 13, byte-address width of instruction memory (2**IMEM_W bytes)
STARVE_MAX, 8, consecutive denied debug-request cycles before debug is forced a slot

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
boot_skip_i  in  1  leave LOAD without loading (memory pre-initialised)
reload_i  in  1  single-cycle pulse: return to LOAD from RUN
core_rst_o  out  1  holds pipeline in reset while in LOAD
fetch_req_i  in  1  fetch read request
fetch_addr_i  in  IMEM_W  fetch byte address
fetch_rdata_o  out  WIDTH  registered fetch instruction
fetch_valid_o  out  1  fetch_rdata_o valid this cycle
fetch_stall_o  out  1  fetch request not served this cycle
ld_valid_i  in  1  loader write beat valid
ld_ready_o  out  1  controller accepts loader beat
ld_addr_i  in  IMEM_W  loader byte address
ld_data_i  in  WIDTH  loader write data
ld_last_i  in  1  final beat of program
ld_err_o  out  1  sticky: misaligned loader address seen
dbg_req_i  in  1  debug read request
dbg_addr_i  in  IMEM_W  debug byte address
dbg_rdata_o  out  WIDTH  registered debug read data
dbg_valid_o  out  1  dbg_rdata_o valid this cycle
mem_addr_o  out  IMEM_W  byte address to imem
mem_we_o  out  1  imem write enable
mem_wdata_o  out  WIDTH  imem write data
mem_rdata_i  in  WIDTH  imem combinational read data
state_o  out  2  FSM state (0 = LOAD, 1 = RUN)

Behaviour:
- The single clock is clk_i; reset is rst_i, synchronous and active-high.
- Reset values:
  - state = LOAD
  - core_rst_o = 1, ld_ready_o = 1
  - fetch_valid_o, dbg_valid_o, fetch_stall_o, ld_err_o, mem_we_o = 0
  - fetch_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o = 0
  - starvation counter = 0
- FSM:
  - LOAD -> RUN on an accepted beat (ld_valid_i & ld_ready_o) with ld_last_i = 1, or when boot_skip_i = 1.
  - RUN -> LOAD on reload_i = 1.
- LOAD state:
  - core_rst_o = 1, ld_ready_o = 1, fetch_stall_o = 0.
  - Fetch and debug requests are ignored; their valids stay 0.
  - Accepted beat: mem_addr_o = ld_addr_i, mem_wdata_o = ld_data_i, mem_we_o = 1 in the same cycle (combinational drive).
  - If ld_addr_i[1:0] != 0, mem_we_o = 0, the beat is still accepted, and ld_err_o sets. ld_err_o clears only on rst_i.
- RUN state:
  - core_rst_o = 0, ld_ready_o = 0, mem_we_o = 0.
  - Grant priority: fetch, unless the starvation counter equals STARVE_MAX and dbg_req_i = 1, in which case debug wins that cycle.
  - Granted requester's address drives mem_addr_o. mem_rdata_i is registered into its rdata_o, and its valid_o pulses high the next cycle. Read latency = 1.
  - fetch_stall_o = fetch_req_i & ~fetch_grant, combinational, same cycle.
  - Starvation counter:
    - increments (saturating at STARVE_MAX) on each cycle dbg_req_i = 1 and debug is not granted;
    - clears on a debug grant or when dbg_req_i = 0.
  - Debug is also granted whenever fetch_req_i = 0.
- Simultaneous events:
  - reload_i in RUN together with a fetch grant: that read completes (valid next cycle), then the state is LOAD.
  - boot_skip_i and an accepted ld_last_i beat in the same cycle: the write is performed and the state goes to RUN.
  - rst_i overrides everything. Mid-load reset returns to LOAD with no write that cycle.
- Address bits [1:0] are passed through to mem_addr_o; the memory ignores them on read.

Optional Feature:
IMEM_CTRL_DBG_EN
- Defined: debug port, arbitration and starvation counter are present as above.
- Undefined: dbg_rdata_o = 0 and dbg_valid_o = 0 constantly, and dbg_req_i is ignored. Fetch is granted every RUN cycle, so fetch_stall_o is always 0 in RUN. No starvation counter logic is synthesised.

Test Plan:
- Reset, loader writes 0x13 @0x0, 0x6F @0x4 (last) -> mem_we_o pulses at 0x0 then 0x4; state_o 0 -> 1 after second beat; core_rst_o falls the same cycle state_o goes to 1.
- RUN, fetch_req_i = 1, fetch_addr_i = 0x4, memory holds 0x0000006F -> fetch_valid_o = 1 and fetch_rdata_o = 0x0000006F one cycle later; fetch_stall_o = 0.
- Fetch held high, dbg_req_i = 1 @0x0 continuously -> debug denied 8 cycles, granted on cycle 9: fetch_stall_o = 1 that cycle, dbg_valid_o = 1 with 0x00000013 the next cycle.
- Loader beat with ld_addr_i = 0x6 -> ld_ready_o = 1, mem_we_o = 0, ld_err_o = 1 and sticky until rst_i.
- RUN, reload_i pulse during an active fetch -> fetch_valid_o still asserts next cycle; state_o = 0, core_rst_o = 1, ld_ready_o = 1.
- boot_skip_i = 1 right after reset -> RUN next cycle with zero memory writes.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction memory controller: shares one single-port imem between loader, fetch and debug.
// Optional debug port and starvation arbitration are enabled by defining IMEM_CTRL_DBG_EN.
module imem_ctrl #(
    parameter int WIDTH      = 32,
    parameter int IMEM_W     = 13,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              boot_skip_i,
    input  logic              reload_i,
    output logic              core_rst_o,
    input  logic              fetch_req_i,
    input  logic [IMEM_W-1:0] fetch_addr_i,
    output logic [WIDTH-1:0]  fetch_rdata_o,
    output logic              fetch_valid_o,
    output logic              fetch_stall_o,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [IMEM_W-1:0] ld_addr_i,
    input  logic [WIDTH-1:0]  ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_err_o,
    input  logic              dbg_req_i,
    input  logic [IMEM_W-1:0] dbg_addr_i,
    output logic [WIDTH-1:0]  dbg_rdata_o,
    output logic              dbg_valid_o,
    output logic [IMEM_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1
    } state_t;

    state_t state, state_next;
    logic   ld_accept;
    logic   fetch_grant;
    logic   dbg_grant;
    logic   dbg_force;

`ifdef IMEM_CTRL_DBG_EN
    logic [CNT_W-1:0] starve_cnt;
    assign dbg_force = dbg_req_i && (starve_cnt == STARVE_LIM);
`else
    assign dbg_force = 1'b0;
`endif

    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= LOAD;
        else
            state <= state_next;
    end

    // Reset forces the LOAD-style handshake outputs but blocks any write.
    always_comb begin
        state_next    = state;
        core_rst_o    = 1'b1;
        ld_ready_o    = 1'b0;
        fetch_stall_o = 1'b0;
        mem_addr_o    = '0;
        mem_we_o      = 1'b0;
        mem_wdata_o   = '0;
        ld_accept     = 1'b0;
        fetch_grant   = 1'b0;
        dbg_grant     = 1'b0;
        if (rst_i) begin
            ld_ready_o = 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    ld_ready_o  = 1'b1;
                    ld_accept   = ld_valid_i;
                    mem_addr_o  = ld_addr_i;
                    mem_wdata_o = ld_data_i;
                    mem_we_o    = ld_valid_i && (ld_addr_i[1:0] == 2'b00);
                    if ((ld_valid_i && ld_last_i) || boot_skip_i)
                        state_next = RUN;
                end
                RUN: begin
                    core_rst_o = 1'b0;
`ifdef IMEM_CTRL_DBG_EN
                    fetch_grant = fetch_req_i && !dbg_force;
                    dbg_grant   = dbg_req_i && (dbg_force || !fetch_req_i);
`else
                    fetch_grant = fetch_req_i;
`endif
                    mem_addr_o    = dbg_grant ? dbg_addr_i : fetch_addr_i;
                    fetch_stall_o = fetch_req_i && !fetch_grant;
                    if (reload_i)
                        state_next = LOAD;
                end
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_valid_o <= 1'b0;
            fetch_rdata_o <= '0;
            ld_err_o      <= 1'b0;
        end else begin
            fetch_valid_o <= fetch_grant;
            if (fetch_grant)
                fetch_rdata_o <= mem_rdata_i;
            if (ld_accept && (ld_addr_i[1:0] != 2'b00))
                ld_err_o <= 1'b1;
        end
    end

`ifdef IMEM_CTRL_DBG_EN
    // Counter tracks consecutive denied debug cycles; it saturates so the force stays asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dbg_valid_o <= 1'b0;
            dbg_rdata_o <= '0;
            starve_cnt  <= '0;
        end else begin
            dbg_valid_o <= dbg_grant;
            if (dbg_grant)
                dbg_rdata_o <= mem_rdata_i;
            if ((state != RUN) || !dbg_req_i || dbg_grant)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign dbg_valid_o = 1'b0;
    assign dbg_rdata_o = '0;
    wire unused_dbg = ^{dbg_req_i, dbg_force, STARVE_LIM};
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: table-driven RUN vectors, scoreboarded reads, corner sequences.
module tb_imem_ctrl;

    localparam int WIDTH      = 32;
    localparam int IMEM_W     = 13;
    localparam int STARVE_MAX = 8;
`ifdef IMEM_CTRL_DBG_EN
    localparam logic DBG_EN = 1'b1;
`else
    localparam logic DBG_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              boot_skip;
    logic              reload;
    logic              core_rst;
    logic              fetch_req;
    logic [IMEM_W-1:0] fetch_addr;
    logic [WIDTH-1:0]  fetch_rdata;
    logic              fetch_valid;
    logic              fetch_stall;
    logic              ld_valid;
    logic              ld_ready;
    logic [IMEM_W-1:0] ld_addr;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_last;
    logic              ld_err;
    logic              dbg_req;
    logic [IMEM_W-1:0] dbg_addr;
    logic [WIDTH-1:0]  dbg_rdata;
    logic              dbg_valid;
    logic [IMEM_W-1:0] mem_addr;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic [1:0]        state;

    logic [WIDTH-1:0] mem     [0:2047];
    logic [WIDTH-1:0] ref_mem [0:2047];
    int               write_count = 0;

    logic [WIDTH-1:0] fetch_q[$];
    logic [WIDTH-1:0] dbg_q[$];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic              f_req;
        logic [IMEM_W-1:0] f_addr;
        logic              d_req;
        logic [IMEM_W-1:0] d_addr;
        logic              exp_fetch;
        logic              exp_dbg;
    } vec_t;
    vec_t vecs[6];

    imem_ctrl #(.WIDTH(WIDTH), .IMEM_W(IMEM_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk), .rst_i(rst), .boot_skip_i(boot_skip), .reload_i(reload),
        .core_rst_o(core_rst),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_rdata_o(fetch_rdata),
        .fetch_valid_o(fetch_valid), .fetch_stall_o(fetch_stall),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr),
        .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_err_o(ld_err),
        .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_rdata_o(dbg_rdata),
        .dbg_valid_o(dbg_valid),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .state_o(state)
    );

    always #5 clk = ~clk;

    // Behavioural imem: combinational word-indexed read, write on the clock edge.
    assign mem_rdata = mem[mem_addr[IMEM_W-1:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[IMEM_W-1:2]] <= mem_wdata;
            write_count <= write_count + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic f_req, input logic [IMEM_W-1:0] f_addr,
                                 input logic d_req, input logic [IMEM_W-1:0] d_addr);
        fetch_req  = f_req;
        fetch_addr = f_addr;
        dbg_req    = d_req;
        dbg_addr   = d_addr;
    endtask

    // Waits for the falling edge, retires reads granted last cycle, then queues this cycle's grants.
    task automatic sampleEdge(input logic exp_fetch, input logic exp_dbg, input logic in_run);
        logic [WIDTH-1:0] exp_word;
        @(negedge clk);
        checkOutput("fetch_valid", 32'(fetch_valid), 32'(fetch_q.size() != 0));
        if (fetch_q.size() != 0) begin
            exp_word = fetch_q.pop_front();
            if (fetch_valid)
                checkOutput("fetch_rdata", fetch_rdata, exp_word);
        end
        checkOutput("dbg_valid", 32'(dbg_valid), 32'(dbg_q.size() != 0));
        if (dbg_q.size() != 0) begin
            exp_word = dbg_q.pop_front();
            if (dbg_valid)
                checkOutput("dbg_rdata", dbg_rdata, exp_word);
        end
        if (in_run) begin
            checkOutput("fetch_stall", 32'(fetch_stall), 32'(fetch_req & ~exp_fetch));
            checkOutput("run_mem_we", 32'(mem_we), 32'd0);
            if (exp_dbg)
                checkOutput("mem_addr_dbg", 32'(mem_addr), 32'(dbg_addr));
            else if (exp_fetch)
                checkOutput("mem_addr_fetch", 32'(mem_addr), 32'(fetch_addr));
        end
        if (exp_fetch)
            fetch_q.push_back(ref_mem[fetch_addr[IMEM_W-1:2]]);
        if (exp_dbg)
            dbg_q.push_back(ref_mem[dbg_addr[IMEM_W-1:2]]);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wc;
        logic ed;

        vecs[0] = '{1'b1, 13'h4, 1'b0, 13'h0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 13'h0, 1'b0, 13'h0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 13'h0, 1'b1, 13'h4, 1'b0, DBG_EN};
        vecs[3] = '{1'b1, 13'h4, 1'b1, 13'h0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 13'h1, 1'b0, 13'h0, 1'b1, 1'b0};

        rst = 1'b1; boot_skip = 1'b0; reload = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        ld_valid = 1'b1; ld_addr = 13'h8; ld_data = 32'hBAD; ld_last = 1'b0;
        nextCycle();

        // Reset with a loader beat pending: no write may happen.
        sampleEdge(1'b0, 1'b0, 1'b0);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_ld_err", 32'(ld_err), 32'd0);
        checkOutput("rst_fetch_stall", 32'(fetch_stall), 32'd0);
        nextCycle();

        rst = 1'b0;
        ld_valid = 1'b1; ld_addr = 13'h0; ld_data = 32'h13; ld_last = 1'b0;
        applyStimulus(1'b1, 13'h4, 1'b1, 13'h0);
        sampleEdge(1'b0, 1'b0, 1'b0);
        checkOutput("ld0_mem_we", 32'(mem_we), 32'd1);
        checkOutput("ld0_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("ld0_mem_wdata", mem_wdata, 32'h13);
        checkOutput("ld0_state", 32'(state), 32'd0);
        checkOutput("ld0_core_rst", 32'(core_rst), 32'd1);
        checkOutput("ld0_fetch_stall", 32'(fetch_stall), 32'd0);
        ref_mem[0] = 32'h13;
        nextCycle();

        ld_addr = 13'h6; ld_data = 32'hDEAD;
        sampleEdge(1'b0, 1'b0, 1'b0);
        checkOutput("mis_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("mis_mem_we", 32'(mem_we), 32'd0);
        nextCycle();

        ld_addr = 13'h4; ld_data = 32'h6F; ld_last = 1'b1;
        sampleEdge(1'b0, 1'b0, 1'b0);
        checkOutput("ld_err_set", 32'(ld_err), 32'd1);
        checkOutput("ld1_mem_we", 32'(mem_we), 32'd1);
        checkOutput("ld1_mem_addr", 32'(mem_addr), 32'h4);
        checkOutput("ld1_state", 32'(state), 32'd0);
        ref_mem[1] = 32'h6F;
        nextCycle();
        ld_valid = 1'b0; ld_last = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_addr);
            sampleEdge(vecs[i].exp_fetch, vecs[i].exp_dbg, 1'b1);
            if (i == 0) begin
                checkOutput("run_state", 32'(state), 32'd1);
                checkOutput("run_core_rst", 32'(core_rst), 32'd0);
                checkOutput("run_ld_ready", 32'(ld_ready), 32'd0);
            end
            nextCycle();
        end

        // Debug starves behind continuous fetch until the counter saturates.
        applyStimulus(1'b1, 13'h4, 1'b1, 13'h0);
        for (int i = 0; i < 10; i++) begin
            ed = DBG_EN && (i == STARVE_MAX);
            sampleEdge(!ed, ed, 1'b1);
            nextCycle();
        end

        applyStimulus(1'b1, 13'h0, 1'b0, 13'h0);
        reload = 1'b1;
        sampleEdge(1'b1, 1'b0, 1'b1);
        nextCycle();
        reload = 1'b0;

        // Back in LOAD: final beat and boot_skip in the same cycle.
        ld_valid = 1'b1; ld_addr = 13'h8; ld_data = 32'h33; ld_last = 1'b1; boot_skip = 1'b1;
        sampleEdge(1'b0, 1'b0, 1'b0);
        checkOutput("reload_state", 32'(state), 32'd0);
        checkOutput("reload_core_rst", 32'(core_rst), 32'd1);
        checkOutput("reload_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("reload_fetch_stall", 32'(fetch_stall), 32'd0);
        checkOutput("ld_err_sticky", 32'(ld_err), 32'd1);
        checkOutput("skip_last_mem_we", 32'(mem_we), 32'd1);
        checkOutput("skip_last_mem_addr", 32'(mem_addr), 32'h8);
        ref_mem[2] = 32'h33;
        nextCycle();
        ld_valid = 1'b0; ld_last = 1'b0; boot_skip = 1'b0;

        applyStimulus(1'b1, 13'h8, 1'b0, 13'h0);
        sampleEdge(1'b1, 1'b0, 1'b1);
        checkOutput("skip_last_state", 32'(state), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 13'h0, 1'b0, 13'h0);
        sampleEdge(1'b0, 1'b0, 1'b1);
        nextCycle();

        rst = 1'b1;
        sampleEdge(1'b0, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b0; boot_skip = 1'b1;
        wc = write_count;
        sampleEdge(1'b0, 1'b0, 1'b0);
        checkOutput("ld_err_cleared", 32'(ld_err), 32'd0);
        checkOutput("boot_state_load", 32'(state), 32'd0);
        nextCycle();
        boot_skip = 1'b0;
        sampleEdge(1'b0, 1'b0, 1'b1);
        checkOutput("boot_state_run", 32'(state), 32'd1);
        checkOutput("boot_core_rst", 32'(core_rst), 32'd0);
        checkOutput("boot_writes", 32'(write_count - wc), 32'd0);
        nextCycle();

        checkOutput("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
        checkOutput("dbg_q_empty", 32'(dbg_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
